// File: rtl/ciphertext_loader.sv
// Byte-stream front end for the bombe core: filters ASCII letters into a
// ciphertext buffer (1-cycle read port) and a crib register, LF-delimited.
module ciphertext_loader #(
    parameter int MSG_DEPTH = 1024,
    parameter int CRIB_LEN  = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [7:0]                     byte_in,
    input  logic                           byte_valid_in,
    input  logic [$clog2(MSG_DEPTH)-1:0]   rd_addr_in,
    output logic [4:0]                     rd_data_out,
    output logic [$clog2(MSG_DEPTH):0]     msg_len_out,
    output logic [5*CRIB_LEN-1:0]          crib_out,
    output logic [$clog2(CRIB_LEN):0]      crib_len_out,
    output logic                           loaded_out,
    output logic                           overflow_out
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int CLW = $clog2(CRIB_LEN) + 1;
    localparam logic [LW-1:0]  MSG_FULL  = LW'(MSG_DEPTH);
    localparam logic [CLW-1:0] CRIB_FULL = CLW'(CRIB_LEN);

    typedef enum logic [1:0] {
        LOAD_MSG  = 2'd0,
        LOAD_CRIB = 2'd1,
        DONE      = 2'd2
    } state_t;

    // Returns {is_letter, is_lf, letter_index}.
    function automatic logic [6:0] classify(input logic [7:0] b);
        logic [6:0] r;
        if (b >= 8'h41 && b <= 8'h5A) begin
            r = {1'b1, 1'b0, 5'(b - 8'h41)};
        end else if (b >= 8'h61 && b <= 8'h7A) begin
            r = {1'b1, 1'b0, 5'(b - 8'h61)};
        end else if (b == 8'h0A) begin
            r = {1'b0, 1'b1, 5'd0};
        end else begin
            r = 7'd0;
        end
        return r;
    endfunction

    state_t              state_r;
    logic [LW-1:0]       msg_len_r;
    logic [CLW-1:0]      crib_len_r;
    logic [5*CRIB_LEN-1:0] crib_r;
    logic                loaded_r;
    logic                overflow_r;
    logic [4:0]          rd_data_r;
    logic [4:0]          mem_r [MSG_DEPTH];

    logic                letter_s;
    logic                lf_s;
    logic [4:0]          idx_s;
    logic                mem_we_s;

    // Byte decode and buffer write enable; nothing is written on a reset cycle.
    always_comb begin
        logic [6:0] cls;
        cls = classify(byte_in);
        if (byte_valid_in) begin
            letter_s = cls[6];
            lf_s     = cls[5];
        end else begin
            letter_s = 1'b0;
            lf_s     = 1'b0;
        end
        idx_s    = cls[4:0];
        mem_we_s = letter_s && (state_r == LOAD_MSG) && (msg_len_r < MSG_FULL) && !rst_in;
    end

    // Message buffer write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (mem_we_s) begin
            mem_r[msg_len_r[AW-1:0]] <= idx_s;
        end
    end

    // Registered read port, read-before-write on address collision.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_data_r <= 5'd0;
        end else begin
            rd_data_r <= mem_r[rd_addr_in];
        end
    end

    // Load sequencer: message line, then crib line, then hold until reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= LOAD_MSG;
            msg_len_r  <= '0;
            crib_len_r <= '0;
            crib_r     <= '0;
            loaded_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                LOAD_MSG: begin
                    if (letter_s) begin
                        if (msg_len_r < MSG_FULL) begin
                            msg_len_r <= msg_len_r + LW'(1);
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end else if (lf_s && msg_len_r != '0) begin
                        state_r <= LOAD_CRIB;
                    end
                end
                LOAD_CRIB: begin
                    if (letter_s) begin
                        if (crib_len_r < CRIB_FULL) begin
                            crib_r[5*int'(crib_len_r) +: 5] <= idx_s;
                            crib_len_r <= crib_len_r + CLW'(1);
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end else if (lf_s && crib_len_r != '0) begin
                        state_r  <= DONE;
                        loaded_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= LOAD_MSG;
                end
            endcase
        end
    end

    assign rd_data_out  = rd_data_r;
    assign msg_len_out  = msg_len_r;
    assign crib_out     = crib_r;
    assign crib_len_out = crib_len_r;
    assign loaded_out   = loaded_r;
    assign overflow_out = overflow_r;

endmodule
